// File: rtl/matmul_pkg.sv
// matmul_pkg
// Shared definitions for the 8x8 signed matrix-multiply slice: matrix and
// datapath dimensions, the sequencer state encoding, and the linear
// addressing helper used for the column-major A/B RAMs and row-major C RAM.
// Also used by the MAC and RAM wrappers so all blocks agree on widths.

package matmul_pkg;

    localparam int MM_N      = 8;    // matrix dimension (N x N)
    localparam int MM_DATA_W = 8;    // signed operand width
    localparam int MM_ACC_W  = 19;   // signed accumulator width, holds N*128*128
    localparam int MM_ADDR_W = 6;    // log2(N*N)

    localparam int ST_W = 3;

    // Sequencer states (legacy-compatible plain constants).
    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_CLEAR = 3'd1;
    localparam logic [ST_W-1:0] ST_ACCUM = 3'd2;
    localparam logic [ST_W-1:0] ST_DRAIN = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

    typedef logic [ST_W-1:0] state_t;

    // Linear RAM index of (major, minor) in an n x n array: major*n + minor.
    // Column-major A/B use (column, row); row-major C uses (row, column).
    function automatic int lin_index(input int major, input int minor, input int n);
        return major * n + minor;
    endfunction

endpackage

// File: rtl/matmul_index_counter.sv
// matmul_index_counter
// Nested i (row) / j (column) / k (step) counters for the sequencer.
// k runs 0..N inside one element: k=0 is the CLEAR cycle, k=1..N are the
// ACCUM cycles. When k reaches N an enabled step wraps k to 0 and advances
// to the next element (j inner, i outer), wrapping to (0,0) after the last.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr          synchronous return of all counters to zero
//   en           advance one step
//   a_addr       k*N + i   (A is column-major: column k, row i)
//   b_addr       j*N + k   (B is column-major: column j, row k)
//   elem_idx     i*N + j   (C element index)
//   last_k       k == N, final ACCUM cycle of the current element
//   last_elem    current element is (N-1, N-1)

module matmul_index_counter
    import matmul_pkg::*;
#(
    parameter int N      = MM_N,
    parameter int ADDR_W = MM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [ADDR_W-1:0] elem_idx,
    output logic              last_k,
    output logic              last_elem
);

    localparam int IDX_W = $clog2(N);
    // k needs one extra value (N) to mark the last ACCUM cycle.
    localparam int K_W   = $clog2(N + 1);

    logic [IDX_W-1:0] i_q;
    logic [IDX_W-1:0] j_q;
    logic [K_W-1:0]   k_q;
    logic             last_i;
    logic             last_j;

    assign last_k    = (k_q == K_W'(N));
    assign last_i    = (i_q == IDX_W'(N - 1));
    assign last_j    = (j_q == IDX_W'(N - 1));
    assign last_elem = last_i && last_j;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else if (clr) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else if (en) begin
            if (last_k) begin
                k_q <= '0;
                if (last_j) begin
                    j_q <= '0;
                    i_q <= last_i ? '0 : i_q + 1'b1;
                end else begin
                    j_q <= j_q + 1'b1;
                end
            end else begin
                k_q <= k_q + 1'b1;
            end
        end
    end

    // During the k == N cycle these addresses are meaningless; the top
    // gates them off because no read is issued then.
    assign a_addr   = ADDR_W'(lin_index(int'(k_q), int'(i_q), N));
    assign b_addr   = ADDR_W'(lin_index(int'(j_q), int'(k_q), N));
    assign elem_idx = ADDR_W'(lin_index(int'(i_q), int'(j_q), N));

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer
// Control and address sequencer for the N x N signed matrix multiply.
// Reads A/B (1-cycle registered RAMs), feeds a single accumulating MAC,
// and writes each finished dot product into C, indices 0..N*N-1 ascending.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              run request, sampled only in IDLE
//   busy               high during CLEAR/ACCUM/DRAIN
//   done               one-cycle pulse after the last C write
//   a_addr, a_data     A RAM read address / registered read data
//   b_addr, b_data     B RAM read address / registered read data
//   mac_a, mac_b       MAC operands (pass-through of a_data/b_data)
//   mac_clear, mac_en  MAC accumulator clear / accumulate enable
//   mac_out            MAC accumulator value
//   c_addr, c_data, c_we  C RAM write port (c_data is mac_out)
//
// state | meaning
// IDLE  | waiting for start, all strobes and addresses zero
// CLEAR | clear MAC, issue k=0 reads, write previous element (if any)
// ACCUM | N cycles of accumulation, reads k=1..N-1 on the first N-1
// DRAIN | write the final element
// DONE  | one-cycle done pulse, back to IDLE

module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int N      = MM_N,
    parameter int DATA_W = MM_DATA_W,
    parameter int ACC_W  = MM_ACC_W,
    parameter int ADDR_W = MM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_clear,
    output logic              mac_en,
    input  logic [ACC_W-1:0]  mac_out,
    output logic [ADDR_W-1:0] c_addr,
    output logic [ACC_W-1:0]  c_data,
    output logic              c_we
);

    state_t            state_q;
    state_t            state_d;

    logic              in_idle;
    logic              in_clear;
    logic              in_accum;
    logic              in_drain;
    logic              in_done;

    logic              cnt_en;
    logic              cnt_clr;
    logic [ADDR_W-1:0] cnt_a_addr;
    logic [ADDR_W-1:0] cnt_b_addr;
    logic [ADDR_W-1:0] elem_idx;
    logic              last_k;
    logic              last_elem;

    logic              issue;        // A/B read address issued this cycle
    logic              issue_q;      // read data arrives this cycle
    logic              elem_end;     // final ACCUM cycle of an element
    logic              have_prev_q;  // a finished element awaits writing
    logic [ADDR_W-1:0] wr_idx_q;     // index of that finished element

    assign in_idle  = (state_q == ST_IDLE);
    assign in_clear = (state_q == ST_CLEAR);
    assign in_accum = (state_q == ST_ACCUM);
    assign in_drain = (state_q == ST_DRAIN);
    assign in_done  = (state_q == ST_DONE);

    assign cnt_en   = in_clear || in_accum;
    assign cnt_clr  = in_idle;
    assign elem_end = in_accum && last_k;
    assign issue    = in_clear || (in_accum && !last_k);

    matmul_index_counter #(
        .N      (N),
        .ADDR_W (ADDR_W)
    ) u_index_counter (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .a_addr    (cnt_a_addr),
        .b_addr    (cnt_b_addr),
        .elem_idx  (elem_idx),
        .last_k    (last_k),
        .last_elem (last_elem)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_ACCUM;
            ST_ACCUM: if (last_k) state_d = last_elem ? ST_DRAIN : ST_CLEAR;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            issue_q     <= 1'b0;
            have_prev_q <= 1'b0;
            wr_idx_q    <= '0;
        end else begin
            state_q <= state_d;
            // Delaying the issue flag by the RAM latency lines mac_en up
            // with the data that address produced.
            issue_q <= issue;
            if (in_idle) begin
                have_prev_q <= 1'b0;
            end else if (elem_end) begin
                have_prev_q <= 1'b1;
                wr_idx_q    <= elem_idx;
            end
        end
    end

    assign busy      = in_clear || in_accum || in_drain;
    assign done      = in_done;

    assign a_addr    = issue ? cnt_a_addr : '0;
    assign b_addr    = issue ? cnt_b_addr : '0;

    assign mac_a     = a_data;
    assign mac_b     = b_data;
    assign mac_clear = in_clear;
    assign mac_en    = issue_q;

    // The clear lands at the end of CLEAR, so mac_out still holds the
    // completed sum of the previous element during that cycle.
    assign c_we      = (in_clear && have_prev_q) || in_drain;
    assign c_addr    = c_we ? wr_idx_q : '0;
    assign c_data    = mac_out;

endmodule

// File: tb/tb_matmul_sequencer.sv
`timescale 1ns/1ps
module tb_matmul_sequencer;

    localparam int N      = 8;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 19;
    localparam int ADDR_W = 6;
    localparam int RUN_LEN = 578;

    typedef struct packed {
        logic [ADDR_W-1:0]       addr;
        logic signed [ACC_W-1:0] data;
    } exp_t;

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic                     busy;
    logic                     done;
    logic [ADDR_W-1:0]        a_addr;
    logic signed [DATA_W-1:0] a_data;
    logic [ADDR_W-1:0]        b_addr;
    logic signed [DATA_W-1:0] b_data;
    logic signed [DATA_W-1:0] mac_a;
    logic signed [DATA_W-1:0] mac_b;
    logic                     mac_clear;
    logic                     mac_en;
    logic signed [ACC_W-1:0]  mac_out;
    logic [ADDR_W-1:0]        c_addr;
    logic signed [ACC_W-1:0]  c_data;
    logic                     c_we;

    logic signed [DATA_W-1:0] a_mem [0:N*N-1];
    logic signed [DATA_W-1:0] b_mem [0:N*N-1];
    logic signed [15:0]       prod;

    exp_t exp_q[$];
    exp_t mon_e;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int done_count = 0;
    int done_cyc = 0;
    int wr_count = 0;

    matmul_sequencer #(
        .N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .a_addr(a_addr), .a_data(a_data), .b_addr(b_addr), .b_data(b_data),
        .mac_a(mac_a), .mac_b(mac_b), .mac_clear(mac_clear), .mac_en(mac_en),
        .mac_out(mac_out), .c_addr(c_addr), .c_data(c_data), .c_we(c_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 1-cycle registered RAM models
    always @(posedge clk) begin
        a_data <= a_mem[a_addr];
        b_data <= b_mem[b_addr];
    end

    // Behavioural MAC
    assign prod = mac_a * mac_b;
    always @(posedge clk or posedge rst) begin
        if (rst)            mac_out <= '0;
        else if (mac_clear) mac_out <= '0;
        else if (mac_en)    mac_out <= mac_out + {{(ACC_W-16){prod[15]}}, prod};
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_count = done_count + 1;
                done_cyc = cyc;
            end
            if (c_we) begin
                wr_count = wr_count + 1;
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL c_write_extra: addr=%0d data=%0d, required no write", c_addr, c_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (c_addr !== mon_e.addr || c_data !== mon_e.data) begin
                        errors = errors + 1;
                        $display("FAIL c_write: addr=%0d data=%0d, required addr=%0d data=%0d",
                                 c_addr, c_data, mon_e.addr, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, " busy"}, int'(busy), 0);
        chk({name, " done"}, int'(done), 0);
        chk({name, " mac_clear"}, int'(mac_clear), 0);
        chk({name, " mac_en"}, int'(mac_en), 0);
        chk({name, " c_we"}, int'(c_we), 0);
        chk({name, " a_addr"}, int'(a_addr), 0);
        chk({name, " b_addr"}, int'(b_addr), 0);
        chk({name, " c_addr"}, int'(c_addr), 0);
        chk({name, " c_data"}, int'(c_data), int'(mac_out));
    endtask

    task automatic fill_const(input int av, input int bv);
        for (int a = 0; a < N*N; a++) begin
            a_mem[a] = DATA_W'(av);
            b_mem[a] = DATA_W'(bv);
        end
    endtask

    // A identity (column-major), B[addr] = addr
    task automatic fill_identity();
        for (int a = 0; a < N*N; a++) begin
            a_mem[a] = ((a / N) == (a % N)) ? 8'sd1 : 8'sd0;
            b_mem[a] = DATA_W'(a);
        end
    endtask

    task automatic push_const(input int v);
        exp_t x;
        for (int e = 0; e < N*N; e++) begin
            x.addr = ADDR_W'(e);
            x.data = ACC_W'(v);
            exp_q.push_back(x);
        end
    endtask

    // C[i*8+j] = j*8+i for the identity test
    task automatic push_identity();
        exp_t x;
        for (int e = 0; e < N*N; e++) begin
            x.addr = ADDR_W'(e);
            x.data = ACC_W'((e % N) * N + (e / N));
            exp_q.push_back(x);
        end
    endtask

    task automatic wait_done(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (done_count < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_count < target) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s timeout: done_count=%0d, required %0d", name, done_count, target);
        end
    endtask

    task automatic run_one(input string name);
        int t0, d0, w0;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        d0 = done_count;
        w0 = wr_count;
        @(negedge clk);
        start = 1'b0;
        chk({name, " busy_c1"}, int'(busy), 1);
        wait_done(name, d0 + 1, 700);
        chk({name, " done_cycle"}, done_cyc - t0, RUN_LEN);
        chk({name, " writes"}, wr_count - w0, 64);
        chk({name, " queue_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int t0, d0, w0;
        rst = 1'b1;
        start = 1'b0;
        fill_const(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_idle("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk_idle("after_reset");

        fill_const(1, 1);
        push_const(8);
        run_one("ones");

        fill_identity();
        push_identity();
        run_one("identity");

        fill_const(-128, -128);
        push_const(131072);
        run_one("neg_neg");

        fill_const(-128, 127);
        push_const(-130048);
        run_one("neg_pos");

        // start held high through the run, with a toggle at cycle 300;
        // still high at cycle 579, which must begin a second identical run
        fill_const(2, -3);
        push_const(-48);
        push_const(-48);
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        d0 = done_count;
        w0 = wr_count;
        while (cyc < t0 + 300) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        wait_done("hold_run1", d0 + 1, 700);
        chk("hold done_cycle1", done_cyc - t0, RUN_LEN);
        chk("hold writes1", wr_count - w0, 64);
        @(negedge clk);
        #1;
        chk("hold busy_579", int'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("hold busy_580", int'(busy), 1);
        wait_done("hold_run2", d0 + 2, 700);
        chk("hold done_cycle2", done_cyc - t0, 579 + RUN_LEN);
        repeat (10) @(negedge clk);
        #1;
        chk("hold done_count", done_count - d0, 2);
        chk("hold writes_total", wr_count - w0, 128);
        chk("hold busy_end", int'(busy), 0);
        exp_q.delete();

        // reset at cycle 200: elements 0..21 written, nothing afterwards
        fill_const(3, 5);
        for (int e = 0; e < 22; e++) begin
            mon_e.addr = ADDR_W'(e);
            mon_e.data = ACC_W'(120);
            exp_q.push_back(mon_e);
        end
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        w0 = wr_count;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 200) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_idle("midrun_reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("rst writes", wr_count - w0, 22);
        chk("rst queue_left", exp_q.size(), 0);
        chk("rst busy", int'(busy), 0);
        exp_q.delete();

        push_const(120);
        run_one("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
